// File: rtl/scarv_cop_pmul_seq_pkg.sv
// Shared definitions for the sequential packed multiplier:
// pack-width encodings, FSM states and lane helpers.
package scarv_cop_pmul_seq_pkg;

    localparam logic [2:0] SCARV_COP_PW_1  = 3'b001;
    localparam logic [2:0] SCARV_COP_PW_2  = 3'b010;
    localparam logic [2:0] SCARV_COP_PW_4  = 3'b100;
    localparam logic [2:0] SCARV_COP_PW_8  = 3'b101;
    localparam logic [2:0] SCARV_COP_PW_16 = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Lane width in bits for a pack width; 0 marks an unsupported encoding.
    function automatic logic [5:0] lane_width(input logic [2:0] pw);
        case (pw)
            SCARV_COP_PW_1:  lane_width = 6'd32;
            SCARV_COP_PW_2:  lane_width = 6'd16;
            SCARV_COP_PW_4:  lane_width = 6'd8;
            SCARV_COP_PW_8:  lane_width = 6'd4;
            SCARV_COP_PW_16: lane_width = 6'd2;
            default:         lane_width = 6'd0;
        endcase
    endfunction

    // Pick the low or high half of every 2W-bit accumulator lane and pack
    // them into W-bit result lanes.
    function automatic logic [31:0] pack_result(input logic [63:0] acc,
                                                input logic [2:0]  pw,
                                                input logic        high);
        logic [31:0] res;
        res = '0;
        case (pw)
            SCARV_COP_PW_1:
                res = high ? acc[63:32] : acc[31:0];
            SCARV_COP_PW_2:
                for (int k = 0; k < 2; k++)
                    res[16*k +: 16] = acc[32*k + (high ? 16 : 0) +: 16];
            SCARV_COP_PW_4:
                for (int k = 0; k < 4; k++)
                    res[8*k +: 8] = acc[16*k + (high ? 8 : 0) +: 8];
            SCARV_COP_PW_8:
                for (int k = 0; k < 8; k++)
                    res[4*k +: 4] = acc[8*k + (high ? 4 : 0) +: 4];
            SCARV_COP_PW_16:
                for (int k = 0; k < 16; k++)
                    res[2*k +: 2] = acc[4*k + (high ? 2 : 0) +: 2];
            default:
                res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/scarv_cop_pmul_step.sv
// One shift-and-add (or shift-and-xor) iteration applied to every lane at
// once. Each lane accumulates into its own 2W-bit slice, so carries never
// leak into the neighbouring lane.
module scarv_cop_pmul_step
    import scarv_cop_pmul_seq_pkg::*;
(
    input  logic [63:0] i_acc,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [2:0]  i_pw,
    input  logic [4:0]  i_idx,
    input  logic        i_ncarry,
    output logic [63:0] o_acc
);

    logic [63:0] w_acc_w [5];

    for (genvar g = 0; g < 5; g++) begin : g_width
        localparam int LW = 32 >> g;
        localparam int SW = $clog2(LW);
        localparam int NL = 32 / LW;

        logic [63:0] w_acc;

        for (genvar k = 0; k < NL; k++) begin : g_lane
            logic [LW-1:0]   w_ak;
            logic [LW-1:0]   w_bk;
            logic            w_bit;
            logic [2*LW-1:0] w_pp;
            logic [2*LW-1:0] w_acck;

            assign w_ak   = i_a[LW*k +: LW];
            assign w_bk   = i_b[LW*k +: LW];
            assign w_bit  = w_bk[i_idx[SW-1:0]];
            assign w_pp   = {{LW{1'b0}}, w_ak & {LW{w_bit}}} << i_idx[SW-1:0];
            assign w_acck = i_acc[2*LW*k +: 2*LW];
            assign w_acc[2*LW*k +: 2*LW] = i_ncarry ? (w_acck ^ w_pp)
                                                    : (w_acck + w_pp);
        end

        assign w_acc_w[g] = w_acc;
    end

    // Select the lane geometry that matches the captured pack width.
    always_comb begin
        case (i_pw)
            SCARV_COP_PW_1:  o_acc = w_acc_w[0];
            SCARV_COP_PW_2:  o_acc = w_acc_w[1];
            SCARV_COP_PW_4:  o_acc = w_acc_w[2];
            SCARV_COP_PW_8:  o_acc = w_acc_w[3];
            SCARV_COP_PW_16: o_acc = w_acc_w[4];
            default:         o_acc = i_acc;
        endcase
    end

endmodule

// File: rtl/scarv_cop_pmul_seq.sv
// Sequential packed multiplier: one multiplier bit per cycle across all
// lanes, answering the packed ALU's start/done handshake.
module scarv_cop_pmul_seq
    import scarv_cop_pmul_seq_pkg::*;
(
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        start,
    output logic        done,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  pw,
    input  logic        high,
    input  logic        ncarry,
    output logic [31:0] result
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [2:0]  r_pw;
    logic        r_high;
    logic        r_ncarry;
    logic [4:0]  r_cnt;
    logic [63:0] r_acc;
    logic [31:0] r_result;

    logic [5:0]  w_lw;
    logic        w_last;
    logic        w_legal;
    logic [63:0] w_acc_nxt;

    assign w_lw    = lane_width(r_pw);
    assign w_last  = ({1'b0, r_cnt} == (w_lw - 6'd1));
    assign w_legal = (lane_width(pw) != 6'd0);

    scarv_cop_pmul_step u_step (
        .i_acc    (r_acc),
        .i_a      (r_a),
        .i_b      (r_b),
        .i_pw     (r_pw),
        .i_idx    (r_cnt),
        .i_ncarry (r_ncarry),
        .o_acc    (w_acc_nxt)
    );

    // Next-state logic; a dropped start during RUN is a flush.
    always_comb begin
        // NOTE: default first so every path assigns w_state_nxt and no latch is inferred.
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_nxt = w_legal ? ST_RUN : ST_DONE;
            ST_RUN: begin
                if (!start)      w_state_nxt = ST_IDLE;
                else if (w_last) w_state_nxt = ST_DONE;
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!g_resetn) r_state <= ST_IDLE;
        else           r_state <= w_state_nxt;
    end

    // Operand capture, per-cycle accumulation and result registration.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            r_a      <= '0;
            r_b      <= '0;
            r_pw     <= '0;
            r_high   <= 1'b0;
            r_ncarry <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_pw     <= pw;
                        r_high   <= high;
                        r_ncarry <= ncarry;
                        r_cnt    <= '0;
                        r_acc    <= '0;
                        if (!w_legal) r_result <= '0;
                    end
                end
                ST_RUN: begin
                    if (start) begin
                        r_acc <= w_acc_nxt;
                        r_cnt <= r_cnt + 5'd1;
                        if (w_last) r_result <= pack_result(w_acc_nxt, r_pw, r_high);
                    end
                end
                default: ;
            endcase
        end
    end

    assign done   = (r_state == ST_DONE);
    assign result = r_result;

endmodule

// File: tb/tb_scarv_cop_pmul_seq.sv
// Self-checking bench for scarv_cop_pmul_seq: scoreboard of expected
// results and latencies, compared when done pulses.
module tb_scarv_cop_pmul_seq;

    logic        g_clk = 1'b0;
    logic        g_resetn;
    logic        start;
    logic        done;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  pw;
    logic        high;
    logic        ncarry;
    logic [31:0] result;

    typedef struct {
        logic [31:0] res;
        int          lat;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] last_res = '0;

    scarv_cop_pmul_seq dut (
        .g_clk    (g_clk),
        .g_resetn (g_resetn),
        .start    (start),
        .done     (done),
        .a        (a),
        .b        (b),
        .pw       (pw),
        .high     (high),
        .ncarry   (ncarry),
        .result   (result)
    );

    always #5 g_clk = ~g_clk;

    function automatic int lw_of(input logic [2:0] p);
        case (p)
            3'b001:  return 32;
            3'b010:  return 16;
            3'b100:  return 8;
            3'b101:  return 4;
            3'b110:  return 2;
            default: return 0;
        endcase
    endfunction

    // Reference: full per-lane product, then pick a half.
    function automatic logic [31:0] model(input logic [31:0] ia, input logic [31:0] ib,
                                          input logic [2:0] ip, input logic ih, input logic inc);
        int          w;
        logic [63:0] mask, ak, bk, p, lane;
        logic [31:0] res;
        w   = lw_of(ip);
        res = '0;
        if (w == 0) return '0;
        mask = (64'd1 << w) - 64'd1;
        for (int k = 0; k < 32 / w; k++) begin
            ak = ({32'd0, ia} >> (w * k)) & mask;
            bk = ({32'd0, ib} >> (w * k)) & mask;
            if (inc) begin
                p = '0;
                for (int i = 0; i < w; i++)
                    if (bk[i]) p = p ^ (ak << i);
            end else begin
                p = ak * bk;
            end
            lane = ih ? ((p >> w) & mask) : (p & mask);
            res  = res | 32'(lane << (w * k));
        end
        return res;
    endfunction

    // Present an operation (at a negedge) and queue its expected outcome.
    task automatic drive_exp(input logic [31:0] ia, input logic [31:0] ib, input logic [2:0] ip,
                             input logic ih, input logic inc, input logic [31:0] ex);
        exp_t e;
        a = ia; b = ib; pw = ip; high = ih; ncarry = inc; start = 1'b1;
        e.res = ex;
        e.lat = (lw_of(ip) == 0) ? 1 : lw_of(ip) + 1;
        sb_q.push_back(e);
    endtask

    task automatic drive(input logic [31:0] ia, input logic [31:0] ib, input logic [2:0] ip,
                         input logic ih, input logic inc);
        drive_exp(ia, ib, ip, ih, inc, model(ia, ib, ip, ih, inc));
    endtask

    // Wait (bounded) for done and compare against the scoreboard head.
    // skip=1 when start is held across a previous DONE cycle.
    task automatic collect(input bit skip, input string name);
        exp_t e;
        int   n;
        bit   got;
        if (skip) @(posedge g_clk);
        n = 0; got = 0;
        while (!got && n < 100) begin
            @(posedge g_clk);
            n++;
            @(negedge g_clk);
            if (done === 1'b1) got = 1;
        end
        if (sb_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL %s: scoreboard empty", name);
            return;
        end
        e = sb_q.pop_front();
        n_cmp++;
        if (!got) begin
            n_err++;
            $display("FAIL %s: done timeout, got none, want at cycle %0d", name, e.lat);
            return;
        end
        if (result !== e.res) begin
            n_err++;
            $display("FAIL %s result: got %h want %h", name, result, e.res);
        end
        n_cmp++;
        if (n !== e.lat) begin
            n_err++;
            $display("FAIL %s latency: got %0d want %0d", name, n, e.lat);
        end
        last_res = e.res;
    endtask

    // Drop start after done and confirm done was a single-cycle pulse.
    task automatic finish_op(input string name);
        start = 1'b0;
        @(negedge g_clk);
        n_cmp++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL %s pulse: done got %b want 0", name, done);
        end
    endtask

    task automatic test_reset();
        g_resetn = 1'b0; start = 1'b0;
        a = '0; b = '0; pw = 3'b001; high = 1'b0; ncarry = 1'b0;
        #1;
        n_cmp++;
        if (done !== 1'b0 || result !== 32'h0) begin
            n_err++;
            $display("FAIL reset: done=%b result=%h want 0/00000000", done, result);
        end
        repeat (2) @(negedge g_clk);
        g_resetn = 1'b1;
        @(negedge g_clk);
    endtask

    task automatic test_pw1();
        drive_exp(32'hFFFFFFFF, 32'hFFFFFFFF, 3'b001, 1'b0, 1'b0, 32'h00000001);
        collect(0, "pw1_lo"); finish_op("pw1_lo");
        drive_exp(32'hFFFFFFFF, 32'hFFFFFFFF, 3'b001, 1'b1, 1'b0, 32'hFFFFFFFE);
        collect(0, "pw1_hi"); finish_op("pw1_hi");
    endtask

    task automatic test_pw2();
        drive_exp(32'h0003FFFF, 32'h00050002, 3'b010, 1'b0, 1'b0, 32'h000FFFFE);
        collect(0, "pw2_lo"); finish_op("pw2_lo");
        drive_exp(32'h0003FFFF, 32'h00050002, 3'b010, 1'b1, 1'b0, 32'h00000001);
        collect(0, "pw2_hi"); finish_op("pw2_hi");
    endtask

    task automatic test_clmul();
        drive_exp(32'h3, 32'h3, 3'b001, 1'b0, 1'b1, 32'h00000005);
        collect(0, "clmul_lo"); finish_op("clmul_lo");
        drive_exp(32'h3, 32'h3, 3'b001, 1'b0, 1'b0, 32'h00000009);
        collect(0, "imul_lo"); finish_op("imul_lo");
        drive_exp(32'h3, 32'h3, 3'b001, 1'b1, 1'b1, 32'h00000000);
        collect(0, "clmul_hi"); finish_op("clmul_hi");
    endtask

    task automatic test_lanes();
        drive_exp(32'h102030FF, 32'h100202FF, 3'b100, 1'b1, 1'b0, 32'h010000FE);
        collect(0, "pw4_hi"); finish_op("pw4_hi");
    endtask

    task automatic test_flush_reset();
        bit seen;
        // Flush: start dropped in the middle of a PW_1 operation.
        a = 32'h12345678; b = 32'h9ABCDEF0; pw = 3'b001; high = 1'b0; ncarry = 1'b0;
        start = 1'b1;
        repeat (5) @(posedge g_clk);
        @(negedge g_clk);
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge g_clk);
            if (done === 1'b1) seen = 1;
        end
        n_cmp++;
        if (seen) begin
            n_err++;
            $display("FAIL flush: done pulse got 1 want 0");
        end
        n_cmp++;
        if (result !== last_res) begin
            n_err++;
            $display("FAIL flush hold: result got %h want %h", result, last_res);
        end
        // Restart right away: must come from IDLE with the short latency.
        drive_exp(32'h3, 32'h3, 3'b110, 1'b0, 1'b0, 32'h00000001);
        collect(0, "restart_pw16"); finish_op("restart_pw16");
        // Asynchronous reset in the middle of RUN.
        drive_exp(32'hFFFFFFFF, 32'hFFFFFFFF, 3'b001, 1'b0, 1'b0, 32'h0);
        void'(sb_q.pop_back());
        repeat (4) @(posedge g_clk);
        #2 g_resetn = 1'b0;
        #1;
        n_cmp++;
        if (done !== 1'b0 || result !== 32'h0) begin
            n_err++;
            $display("FAIL async reset: done=%b result=%h want 0/00000000", done, result);
        end
        start = 1'b0;
        @(negedge g_clk);
        g_resetn = 1'b1;
        @(negedge g_clk);
        last_res = '0;
    endtask

    task automatic test_back_to_back();
        drive_exp(32'h3, 32'h3, 3'b001, 1'b0, 1'b0, 32'h00000009);
        collect(0, "b2b_first");
        // Still in the DONE cycle: new operands, start held high.
        drive_exp(32'hFFFFFFFF, 32'hFFFFFFFF, 3'b110, 1'b1, 1'b0, 32'hAAAAAAAA);
        collect(1, "b2b_second");
        drive_exp(32'hDEADBEEF, 32'h12345678, 3'b111, 1'b0, 1'b0, 32'h00000000);
        collect(1, "b2b_illegal_pw");
        finish_op("b2b_illegal_pw");
    endtask

    task automatic test_random();
        logic [2:0] pws [5] = '{3'b001, 3'b010, 3'b100, 3'b101, 3'b110};
        for (int i = 0; i < 10; i++) begin
            drive($urandom, $urandom, pws[$urandom_range(4, 0)],
                  1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
            collect(0, "random"); finish_op("random");
        end
    endtask

    initial begin
        test_reset();
        test_pw1();
        test_pw2();
        test_clmul();
        test_lanes();
        test_flush_reset();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
